wash_cycle_ctrl: RTL and testbench
==================================

Name: wash_cycle_ctrl

Overview:
- Washing-machine sequencing FSM sitting directly upstream of `timer`.
- Per phase it programs and starts the timer (`timer_period`, `clk_freq`, `timer_clr`, `timer_en`), consumes its `done`, and drives the actuators.
- Phase order: FILL -> WASH -> RINSE -> SPIN. Supports pause and cancel.

Parameters:
- CLK_FREQ, 4'd5, ticks per second; driven unchanged on `clk_freq` (1..15).
- FILL_T, 4'd2, FILL duration in seconds (1..15).
- WASH_T, 4'd5, WASH duration in seconds (1..15).
- RINSE_T, 4'd3, RINSE duration in seconds (1..15).
- SPIN_T, 4'd4, SPIN duration in seconds (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  coin/start request; level sampled in IDLE only.
- pause  input  1  level; holds the current phase while high.
- cancel  input  1  level; aborts the wash and forces drain/spin.
- timer_done  input  1  `done` from `timer`.
- timer_en  output  1  to timer `enable`.
- timer_clr  output  1  to timer `reset`; active-high one-cycle pulse.
- clk_freq  output  4  to timer; constant CLK_FREQ.
- timer_period  output  4  to timer; duration of the current phase.
- water_valve  output  1  high in FILL (and RINSE).
- wash_motor  output  1  high in WASH and RINSE.
- spin_motor  output  1  high in SPIN.
- door_lock  output  1  high in every state except IDLE.
- cycle_done  output  1  one-cycle pulse in COMPLETE.
- state  output  3  encoding: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, COMPLETE=5.

Behaviour:
- Reset (async, reset=0): state=IDLE. All outputs 0 except `clk_freq`=CLK_FREQ and `timer_period`=FILL_T. Reset mid-phase aborts immediately with no drain.
- All outputs are registered and change on the rising edge.
- IDLE: start=1 -> FILL. Entering a phase takes one cycle with `timer_clr`=1, `timer_en`=1 and `timer_period` loaded. Then `timer_clr`=0 and `timer_en`=1 until the phase ends.
- Phase transitions are taken on the edge where timer_done=1, pause=0 and `timer_clr`=0:
  - FILL -> WASH
  - WASH -> RINSE
  - RINSE -> SPIN
  - SPIN -> COMPLETE
- `timer_done` is ignored during the `timer_clr` cycle, so a stale `done` from the previous phase is masked.
- COMPLETE: `cycle_done`=1 and `door_lock`=1 for exactly one cycle, then IDLE.
- Pause (pause=1 in FILL..SPIN):
  - `timer_en`=0, `water_valve`/`wash_motor`/`spin_motor`=0, state held, `door_lock` held at 1.
  - On pause=0 the actuators resume the next cycle and the timer continues; no `timer_clr` pulse.
  - `timer_done` during pause is held off until resume.
- Cancel (cancel=1 in FILL, WASH or RINSE): next state is SPIN with a fresh `timer_clr` pulse and SPIN_T loaded.
  - cancel in SPIN, COMPLETE or IDLE is ignored.
  - Priority: reset > cancel > pause > timer_done.
- start while not in IDLE is ignored. start held high through COMPLETE starts a new cycle from IDLE on the following edge.
- Expected phase length, inclusive of the clr cycle: CLK_FREQ*T_phase + 1 cycles, given timer `done` after CLK_FREQ*period enabled ticks.

Optional Feature:
- Macro: DOUBLE_RINSE_EN.
- Defined:
  - A 1-bit rinse counter is added; RINSE runs twice.
  - First `timer_done` in RINSE -> RINSE again, with a new `timer_clr` pulse and counter=1.
  - Second `timer_done` -> SPIN. Counter clears in IDLE and on cancel.
  - `water_valve` is high during the clr cycle of each rinse.
- Undefined: single RINSE; counter logic absent.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-WASH -> state=0 and all actuators 0 within the same cycle (async); `clk_freq`=5; `timer_period`=FILL_T=2.
- Full cycle: CLK_FREQ=2, FILL/WASH/RINSE/SPIN=1/2/1/1 s with real `timer`, pulse start -> state sequence 1,2,3,4,5,0. `timer_period` 1,2,1,1. Exactly one `cycle_done` pulse. `door_lock`=1 from FILL through COMPLETE.
- Pause: pause=1 for 10 cycles mid-WASH -> `timer_en`=0 and `wash_motor`=0. WASH exit is delayed by exactly 10 cycles versus the unpaused run.
- Cancel: cancel=1 for one cycle in FILL -> next state=SPIN, `timer_clr` pulse, `timer_period`=SPIN_T. cancel in SPIN -> no change.
- Stale done: force timer_done=1 during the `timer_clr` cycle entering WASH -> no transition.
- DOUBLE_RINSE_EN defined: state sequence 1,2,3,3,4,5,0 with two `timer_clr` pulses in RINSE. Undefined: single RINSE.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine phase sequencer driving an external phase timer (FILL -> WASH -> RINSE -> SPIN).
// Define DOUBLE_RINSE_EN to run the RINSE phase twice before SPIN.
module wash_cycle_ctrl #(
    parameter logic [3:0] CLK_FREQ = 4'd5,
    parameter logic [3:0] FILL_T   = 4'd2,
    parameter logic [3:0] WASH_T   = 4'd5,
    parameter logic [3:0] RINSE_T  = 4'd3,
    parameter logic [3:0] SPIN_T   = 4'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic       timer_done,
    output logic       timer_en,
    output logic       timer_clr,
    output logic [3:0] clk_freq,
    output logic [3:0] timer_period,
    output logic       water_valve,
    output logic       wash_motor,
    output logic       spin_motor,
    output logic       door_lock,
    output logic       cycle_done,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL     = 3'd1;
    localparam logic [2:0] S_WASH     = 3'd2;
    localparam logic [2:0] S_RINSE    = 3'd3;
    localparam logic [2:0] S_SPIN     = 3'd4;
    localparam logic [2:0] S_COMPLETE = 3'd5;

    logic [2:0] state_n;
    logic       clr_n;
    logic       en_n;
    logic       hold_n;
    logic       running_n;
    logic [3:0] period_n;
    logic       water_n;
    logic       wash_n;
    logic       spin_n;
    logic       door_n;
    logic       done_n;

`ifdef DOUBLE_RINSE_EN
    logic rinse_cnt;
    logic rinse_cnt_n;
`endif

    function automatic logic [3:0] phase_period(input logic [2:0] s);
        case (s)
            S_WASH:  return WASH_T;
            S_RINSE: return RINSE_T;
            S_SPIN:  return SPIN_T;
            default: return FILL_T;
        endcase
    endfunction

    assign clk_freq = CLK_FREQ;

    // Sequencing: cancel beats pause beats timer_done; done is masked while the clear pulse is out.
    always_comb begin
        state_n = state;
        clr_n   = 1'b0;
        en_n    = 1'b0;
        hold_n  = 1'b0;
`ifdef DOUBLE_RINSE_EN
        rinse_cnt_n = rinse_cnt;
`endif
        case (state)
            S_IDLE: begin
`ifdef DOUBLE_RINSE_EN
                rinse_cnt_n = 1'b0;
`endif
                if (start) begin
                    state_n = S_FILL;
                    clr_n   = 1'b1;
                    en_n    = 1'b1;
                end
            end
            S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                if (cancel && (state != S_SPIN)) begin
                    state_n = S_SPIN;
                    clr_n   = 1'b1;
                    en_n    = 1'b1;
`ifdef DOUBLE_RINSE_EN
                    rinse_cnt_n = 1'b0;
`endif
                end else if (pause) begin
                    hold_n = 1'b1;
                end else if (timer_done && !timer_clr) begin
                    case (state)
                        S_FILL:  state_n = S_WASH;
                        S_WASH:  state_n = S_RINSE;
`ifdef DOUBLE_RINSE_EN
                        S_RINSE: begin
                            state_n     = rinse_cnt ? S_SPIN : S_RINSE;
                            rinse_cnt_n = ~rinse_cnt;
                        end
`else
                        S_RINSE: state_n = S_SPIN;
`endif
                        default: state_n = S_COMPLETE;
                    endcase
                    clr_n = (state != S_SPIN);
                    en_n  = (state != S_SPIN);
                end else begin
                    en_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from where the sequencer is heading.
    always_comb begin
        running_n = !hold_n && (state_n >= S_FILL) && (state_n <= S_SPIN);
        water_n   = running_n && ((state_n == S_FILL) || (state_n == S_RINSE));
        wash_n    = running_n && ((state_n == S_WASH) || (state_n == S_RINSE));
        spin_n    = running_n && (state_n == S_SPIN);
        door_n    = (state_n != S_IDLE);
        done_n    = (state_n == S_COMPLETE);
        period_n  = timer_period;
        if (clr_n)
            period_n = phase_period(state_n);
        else if (state_n == S_IDLE)
            period_n = FILL_T;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            timer_en     <= 1'b0;
            timer_clr    <= 1'b0;
            timer_period <= FILL_T;
            water_valve  <= 1'b0;
            wash_motor   <= 1'b0;
            spin_motor   <= 1'b0;
            door_lock    <= 1'b0;
            cycle_done   <= 1'b0;
        end else begin
            state        <= state_n;
            timer_en     <= en_n;
            timer_clr    <= clr_n;
            timer_period <= period_n;
            water_valve  <= water_n;
            wash_motor   <= wash_n;
            spin_motor   <= spin_n;
            door_lock    <= door_n;
            cycle_done   <= done_n;
        end
    end

`ifdef DOUBLE_RINSE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rinse_cnt <= 1'b0;
        else
            rinse_cnt <= rinse_cnt_n;
    end
`endif

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl with a behavioural phase timer closing the loop.
// Honours DOUBLE_RINSE_EN the same way the design does.
module tb_wash_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, pause, cancel;
    logic       force_done;
    logic       timer_done;
    logic       timer_en, timer_clr;
    logic [3:0] clk_freq, timer_period;
    logic       water_valve, wash_motor, spin_motor, door_lock, cycle_done;
    logic [2:0] state;

    logic [7:0] tcnt;
    logic [7:0] target;
    int         cyc = 0;
    int         cd_pulses = 0;
    int         tests_run = 0;
    int         fail_count = 0;
    int         enter;

    wash_cycle_ctrl dut (
        .clk(clk), .reset(rst_n), .start(start), .pause(pause), .cancel(cancel),
        .timer_done(timer_done), .timer_en(timer_en), .timer_clr(timer_clr),
        .clk_freq(clk_freq), .timer_period(timer_period), .water_valve(water_valve),
        .wash_motor(wash_motor), .spin_motor(spin_motor), .door_lock(door_lock),
        .cycle_done(cycle_done), .state(state)
    );

    always #5 clk = ~clk;

    // Timer: the clear cycle counts as the first enabled tick, done once period*freq ticks are in.
    assign target     = 8'(clk_freq) * 8'(timer_period);
    assign timer_done = (tcnt >= target) || force_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= 8'd0;
        else if (timer_clr)
            tcnt <= timer_en ? 8'd1 : 8'd0;
        else if (timer_en && (tcnt < target))
            tcnt <= tcnt + 8'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (cycle_done) cd_pulses <= cd_pulses + 1;

    task automatic applyStimulus(input logic s, input logic p, input logic c);
        start  = s;
        pause  = p;
        cancel = c;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitLeave(input logic [2:0] from);
        int n = 0;
        while ((state == from) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitClr();
        int n = 0;
        @(negedge clk);
        while (!timer_clr && (n < 200)) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        force_done = 1'b0;
        applyStimulus(0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("rst_state", 16'(state), 16'(0));
        checkOutput("rst_clk_freq", 16'(clk_freq), 16'(5));
        checkOutput("rst_period", 16'(timer_period), 16'(2));
        checkOutput("rst_door", 16'(door_lock), 16'(0));
        checkOutput("rst_en", 16'(timer_en), 16'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_no_start", 16'(state), 16'(0));

        // Full run with a stale done on WASH entry and a 10-cycle pause inside WASH
        applyStimulus(1, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0);
        enter = cyc;
        checkOutput("fill_state", 16'(state), 16'(1));
        checkOutput("fill_clr", 16'(timer_clr), 16'(1));
        checkOutput("fill_en", 16'(timer_en), 16'(1));
        checkOutput("fill_period", 16'(timer_period), 16'(2));
        checkOutput("fill_valve", 16'(water_valve), 16'(1));
        checkOutput("fill_door", 16'(door_lock), 16'(1));
        waitLeave(3'd1);
        checkOutput("fill_len", 16'(cyc - enter), 16'(11));
        enter = cyc;
        checkOutput("wash_state", 16'(state), 16'(2));
        checkOutput("wash_clr", 16'(timer_clr), 16'(1));
        checkOutput("wash_period", 16'(timer_period), 16'(5));
        checkOutput("wash_motor", 16'(wash_motor), 16'(1));
        checkOutput("wash_valve", 16'(water_valve), 16'(0));
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        checkOutput("stale_done_state", 16'(state), 16'(2));
        checkOutput("stale_done_clr", 16'(timer_clr), 16'(0));
        repeat (3) @(negedge clk);
        applyStimulus(0, 1, 0);
        @(negedge clk);
        checkOutput("pause_en", 16'(timer_en), 16'(0));
        checkOutput("pause_motor", 16'(wash_motor), 16'(0));
        checkOutput("pause_door", 16'(door_lock), 16'(1));
        checkOutput("pause_state", 16'(state), 16'(2));
        repeat (9) @(negedge clk);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("resume_en", 16'(timer_en), 16'(1));
        checkOutput("resume_motor", 16'(wash_motor), 16'(1));
        checkOutput("resume_clr", 16'(timer_clr), 16'(0));
        waitLeave(3'd2);
        checkOutput("wash_len_paused", 16'(cyc - enter), 16'(36));
        enter = cyc;
        checkOutput("rinse_state", 16'(state), 16'(3));
        checkOutput("rinse_period", 16'(timer_period), 16'(3));
        checkOutput("rinse_valve", 16'(water_valve), 16'(1));
        checkOutput("rinse_motor", 16'(wash_motor), 16'(1));
`ifdef DOUBLE_RINSE_EN
        waitClr();
        checkOutput("rinse1_len", 16'(cyc - enter), 16'(16));
        checkOutput("rinse2_state", 16'(state), 16'(3));
        checkOutput("rinse2_valve", 16'(water_valve), 16'(1));
        enter = cyc;
`endif
        waitLeave(3'd3);
        checkOutput("rinse_len", 16'(cyc - enter), 16'(16));
        enter = cyc;
        checkOutput("spin_state", 16'(state), 16'(4));
        checkOutput("spin_period", 16'(timer_period), 16'(4));
        checkOutput("spin_motor", 16'(spin_motor), 16'(1));
        checkOutput("spin_wash_off", 16'(wash_motor), 16'(0));
        waitLeave(3'd4);
        checkOutput("spin_len", 16'(cyc - enter), 16'(21));
        checkOutput("complete_state", 16'(state), 16'(5));
        checkOutput("complete_pulse", 16'(cycle_done), 16'(1));
        checkOutput("complete_door", 16'(door_lock), 16'(1));
        checkOutput("complete_en", 16'(timer_en), 16'(0));
        @(negedge clk);
        checkOutput("back_idle", 16'(state), 16'(0));
        checkOutput("idle_pulse_off", 16'(cycle_done), 16'(0));
        checkOutput("idle_door", 16'(door_lock), 16'(0));
        checkOutput("idle_period", 16'(timer_period), 16'(2));
        checkOutput("done_pulses", 16'(cd_pulses), 16'(1));

        // Second run: start held high throughout, cancel in FILL, ignored cancel in SPIN
        applyStimulus(1, 0, 0);
        @(negedge clk);
        checkOutput("run2_fill", 16'(state), 16'(1));
        @(negedge clk);
        applyStimulus(1, 0, 1);
        @(negedge clk);
        applyStimulus(1, 0, 0);
        enter = cyc;
        checkOutput("cancel_state", 16'(state), 16'(4));
        checkOutput("cancel_clr", 16'(timer_clr), 16'(1));
        checkOutput("cancel_period", 16'(timer_period), 16'(4));
        checkOutput("cancel_spin", 16'(spin_motor), 16'(1));
        checkOutput("cancel_valve", 16'(water_valve), 16'(0));
        repeat (3) @(negedge clk);
        applyStimulus(1, 0, 1);
        @(negedge clk);
        applyStimulus(1, 0, 0);
        checkOutput("cancel_in_spin_state", 16'(state), 16'(4));
        checkOutput("cancel_in_spin_clr", 16'(timer_clr), 16'(0));
        waitLeave(3'd4);
        checkOutput("cancel_spin_len", 16'(cyc - enter), 16'(21));
        checkOutput("run2_complete", 16'(state), 16'(5));
        @(negedge clk);
        checkOutput("run2_idle", 16'(state), 16'(0));
        @(negedge clk);
        applyStimulus(0, 0, 0);
        checkOutput("restart_held", 16'(state), 16'(1));

        // Asynchronous reset in the middle of WASH
        waitLeave(3'd1);
        checkOutput("run3_wash", 16'(state), 16'(2));
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_state", 16'(state), 16'(0));
        checkOutput("async_motor", 16'(wash_motor), 16'(0));
        checkOutput("async_door", 16'(door_lock), 16'(0));
        checkOutput("async_en", 16'(timer_en), 16'(0));
        checkOutput("async_period", 16'(timer_period), 16'(2));
        checkOutput("async_clk_freq", 16'(clk_freq), 16'(5));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", 16'(state), 16'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
